// File: rtl/axi4lite_rr_master_arbiter_if.sv
// AXI4-Lite master-side bundle for the round-robin master arbiter.
// Carries the five AXI4-Lite channels (AW, W, B, AR, R) between the arbiter
// and the slave it programs.
//   master modport : drives VALIDs, addresses, write data/strobes, PROT and
//                    the B/R READYs; receives AW/W/AR READYs and responses.
//   slave modport  : the mirror image, used by whatever sits on the far side.
interface axi4lite_rr_master_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                      awvalid;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                awprot;
  logic                      awready;
  logic                      wvalid;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wready;
  logic                      bvalid;
  logic [1:0]                bresp;
  logic                      bready;
  logic                      arvalid;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                arprot;
  logic                      arready;
  logic                      rvalid;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rready;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4lite_rr_master_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master port among N_REQ simple
// requesters, with exactly one AXI transaction outstanding at a time.
// Ports:
//   clk, rst        : single rising-edge clock, synchronous active-high reset
//   req             : per-requester request, held high until its ack
//   req_is_wr       : per-requester direction (1 = write, 0 = read)
//   req_addr        : packed addresses, requester i at slice i
//   req_wdata       : packed write data
//   req_wstrb       : packed write strobes
//   req_ack         : one-hot, one-cycle completion pulse
//   req_rdata       : read data of the completed transaction (0 for writes)
//   req_err         : RESP[1] of the completed transaction
//   busy            : high whenever the FSM is not IDLE
//   m_axi           : AXI4-Lite master channels
// Every output comes straight from a flop.
module axi4lite_rr_master_arbiter #(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               req,
  input  logic [N_REQ-1:0]               req_is_wr,
  input  logic [N_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]    req_wdata,
  input  logic [N_REQ*DATA_WIDTH/8-1:0]  req_wstrb,
  output logic [N_REQ-1:0]               req_ack,
  output logic [DATA_WIDTH-1:0]          req_rdata,
  output logic                           req_err,
  output logic                           busy,
  axi4lite_rr_master_arbiter_if.master   m_axi
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_WIDTH  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                 state_q, state_d;
  logic [IDX_WIDTH-1:0]   grant_q, grant_d;
  logic [IDX_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic                   is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]  wstrb_q, wstrb_d;
  logic                   awvalid_q, awvalid_d;
  logic                   wvalid_q, wvalid_d;
  logic                   arvalid_q, arvalid_d;
  logic                   bready_q, bready_d;
  logic                   rready_q, rready_d;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;
  logic                   resp_done_q, resp_done_d;
  logic [N_REQ-1:0]       ack_q, ack_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;

  logic [N_REQ-1:0]       req_eligible;
  logic                   found;
  logic [IDX_WIDTH-1:0]   pick;
  logic                   aw_now;
  logic                   w_now;

  // Round-robin pick: scan from last_grant+1 with wrap. The requester being
  // acked this cycle still shows req high (it drops it a cycle later), so it
  // is masked out to stop a stale request from being granted again.
  always_comb begin
    req_eligible = req & ~ack_q;
    found        = 1'b0;
    pick         = last_grant_q;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && req_eligible[(int'(last_grant_q) + k) % N_REQ]) begin
        found = 1'b1;
        pick  = IDX_WIDTH'((int'(last_grant_q) + k) % N_REQ);
      end
    end
  end

  // Next-state and output logic. A write tracks its AW and W handshakes
  // separately (they may complete in either order or together); the response
  // is captured in RESP and the ack is pulsed one cycle later.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    is_wr_d      = is_wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    arvalid_d    = arvalid_q;
    bready_d     = bready_q;
    rready_d     = rready_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    resp_done_d  = resp_done_q;
    ack_d        = '0;
    rdata_d      = rdata_q;
    err_d        = err_q;
    aw_now       = aw_done_q | (awvalid_q & m_axi.awready);
    w_now        = w_done_q | (wvalid_q & m_axi.wready);

    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d   = pick;
          is_wr_d   = req_is_wr[pick];
          addr_d    = req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d   = req_wdata[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
          wstrb_d   = req_wstrb[int'(pick)*STRB_WIDTH +: STRB_WIDTH];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (req_is_wr[pick]) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            arvalid_d = 1'b1;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (is_wr_q) begin
          awvalid_d = awvalid_q & ~m_axi.awready;
          wvalid_d  = wvalid_q & ~m_axi.wready;
          aw_done_d = aw_now;
          w_done_d  = w_now;
          if (aw_now && w_now) begin
            bready_d = 1'b1;
            state_d  = RESP;
          end
        end else if (m_axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (resp_done_q) begin
          ack_d          = '0;
          ack_d[grant_q] = 1'b1;
          resp_done_d    = 1'b0;
          last_grant_d   = grant_q;
          state_d        = IDLE;
        end else if (bready_q && m_axi.bvalid) begin
          bready_d    = 1'b0;
          rdata_d     = '0;
          err_d       = m_axi.bresp[1];
          resp_done_d = 1'b1;
        end else if (rready_q && m_axi.rvalid) begin
          rready_d    = 1'b0;
          rdata_d     = m_axi.rdata;
          err_d       = m_axi.rresp[1];
          resp_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State register; reset abandons any in-flight transaction without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= LAST_IDX;
      is_wr_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      bready_q     <= 1'b0;
      rready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      resp_done_q  <= 1'b0;
      ack_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      is_wr_q      <= is_wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      arvalid_q    <= arvalid_d;
      bready_q     <= bready_d;
      rready_q     <= rready_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      resp_done_q  <= resp_done_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
    end
  end

  assign m_axi.awvalid = awvalid_q;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.rready  = rready_q;

  assign req_ack   = ack_q;
  assign req_rdata = rdata_q;
  assign req_err   = err_q;
  assign busy      = busy_q;
endmodule

// File: doc/axi4lite_rr_master_arbiter.md
Name: axi4lite_rr_master_arbiter

Overview:
- Shares one AXI4-Lite master port among N_REQ simple requesters.
- Requesters are test-bench sequencers or internal config engines that program the regblock under test.
- Round-robin grant; exactly one AXI transaction outstanding at a time.
- Completion is returned to the granted requester as a one-cycle ack with read data and an error flag.

Parameters:
- N_REQ, 4, number of requesters (1..16)
- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 32, AXI data width (32 or 64); strobe width is DATA_WIDTH/8

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester request; held high until ack
- req_is_wr  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*ADDR_WIDTH  packed addresses; requester i at slice i
- req_wdata  in  N_REQ*DATA_WIDTH  packed write data
- req_wstrb  in  N_REQ*DATA_WIDTH/8  packed write strobes
- req_ack  out  N_REQ  one-hot, one-cycle completion pulse
- req_rdata  out  DATA_WIDTH  read data; valid when any req_ack is high
- req_err  out  1  RESP[1] of the completed transaction; valid with ack
- busy  out  1  high whenever state is not IDLE
- m_aw*  AWVALID/AWADDR/AWPROT out, AWREADY in
- m_w*  WVALID/WDATA/WSTRB out, WREADY in
- m_b*  BREADY out, BVALID/BRESP in
- m_ar*  ARVALID/ARADDR/ARPROT out, ARREADY in
- m_r*  RREADY out, RVALID/RDATA/RRESP in

Behaviour:
- All outputs are registered.
- Reset values:
  - all VALID/READY outputs 0, req_ack 0, req_rdata 0, req_err 0, busy 0
  - AWADDR/ARADDR/WDATA/WSTRB 0
  - state IDLE
  - RR pointer last_grant = N_REQ-1, so requester 0 wins first
- AWPROT and ARPROT are always 0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req is high, grant the first set bit scanning from last_grant+1 with wrap modulo N_REQ.
  - Latch grant index, is_wr, addr, wdata and wstrb.
  - Next state ISSUE, with VALIDs asserted in the first ISSUE cycle.
  - Write asserts AWVALID and WVALID together; read asserts ARVALID.
- ISSUE, write:
  - Track aw_done and w_done independently.
  - Drop AWVALID the cycle after AWVALID&AWREADY; drop WVALID the cycle after WVALID&WREADY.
  - Address and data stay stable while VALID is high.
  - When both handshakes are complete (including both in the same cycle), go to RESP and set BREADY=1.
- ISSUE, read:
  - Hold ARVALID until ARREADY, then go to RESP and set RREADY=1.
- RESP:
  - Wait for BVALID&BREADY or RVALID&RREADY, then drop READY.
  - Next cycle: pulse req_ack[grant] and set req_err = RESP[1].
  - req_rdata = RDATA for reads, 0 for writes.
  - Set last_grant = grant; return to IDLE.
- Latency: req seen in IDLE -> VALID 1 cycle later. With zero-wait slave (READY=1, response 1 cycle after handshake): read ack 4 cycles after req sampled, write ack 4 cycles.
- A requester drops req in the cycle after it sees ack; the arbiter re-arbitrates at the earliest one cycle after ack. The same requester may be re-granted only if no other req is pending.
- req changes by a non-granted requester never disturb an in-flight transaction. Granted-requester inputs are ignored after latching.
- Grant is never issued while busy. No timeout: a stalled slave stalls the arbiter indefinitely.
- rst mid-transaction: immediate return to reset values next edge; no ack is generated. The slave is expected to be reset alongside.
- N_REQ=1: pointer logic degenerates and the requester is always granted.

Test Plan:
1. Single read, req[0], addr 0x10, slave RDATA 0xDEADBEEF, RRESP 0 -> ARADDR 0x10 for one cycle, req_ack=4'b0001 one cycle, req_rdata 0xDEADBEEF, req_err 0.
2. Single write, req[2], addr 0x4, data 0x12345678, wstrb 0xF; slave AWREADY 3 cycles before WREADY -> AWVALID drops after its handshake while WVALID holds; one B handshake; ack[2]; req_rdata 0.
3. All four req held continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3; never two acks in one cycle; busy gaps at least 1 cycle.
4. SLVERR: BRESP=2'b10 on a write, then RRESP=2'b11 on a read -> req_err 1 on both acks; next transaction OKAY gives req_err 0.
5. Backpressure: slave holds ARREADY low 10 cycles, RVALID 5 cycles late, random ready -> ARVALID/ARADDR stable throughout, RREADY high only in RESP, data matches scoreboard.
6. Reset asserted mid-ISSUE with AWVALID=1 -> next cycle all VALIDs 0, busy 0, no ack; after release, req[0] and req[3] pending -> req[0] granted first.
